apb_uart_tx_fifo: RTL and testbench

Parametrised APB-slave UART transmitter: the next generation of the APB UART TX block. Adds a configurable data width, runtime-selectable parity and stop bits, an N-deep transmit FIFO, and readable status and control registers. It sits on the APB peripheral bus beside the GPIO slave and drives the serial TX pin.

---
 rtl/apb_uart_tx_fifo_pkg.sv | 32 +++
 rtl/apb_uart_tx_fifo_if.sv | 16 +
 rtl/apb_uart_tx_fifo_fifo.sv | 60 ++++++
 rtl/apb_uart_tx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_apb_uart_tx_fifo.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_uart_tx_fifo_pkg.sv
// Shared definitions for the APB UART TX block: register map, bit positions,
// TX FSM encodings and the frame parity helper.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int CTRL_TXEN    = 0;
    localparam int CTRL_PAR_EN  = 1;
    localparam int CTRL_PAR_ODD = 2;
    localparam int CTRL_STOP2   = 3;

    localparam int STAT_EMPTY = 4;
    localparam int STAT_FULL  = 5;
    localparam int STAT_BUSY  = 6;
    localparam int STAT_OVF   = 7;

    localparam logic [3:0] CTRL_RESET = 4'h1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Data must arrive zero-extended so unused high bits do not disturb the XOR.
    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/apb_uart_tx_fifo_if.sv
// APB slave bus bundle for the UART TX block.
interface apb_uart_tx_fifo_if;
    logic       PSEL;
    logic       PENABLE;
    logic [7:0] PADDR;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart_tx_fifo_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer MSB separates
// full from empty. Shared with the future RX path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // Pointer advance, ignoring push when full and pop when empty.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i && !full_o) begin
            wr_d = wr_q + (AW+1)'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_i && !empty_o) begin
            rd_d = rd_q + (AW+1)'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/apb_uart_tx_fifo.sv
// APB UART transmitter: register decode, TX FIFO and the serial frame FSM.
module apb_uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CPB        = 87,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_uart_tx_fifo_if.slave  apb,
    output logic               o_tx,
    output logic               o_tx_done
);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CPB - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    logic                 access_s, wr_data_s, push_s, pop_s, load_s;
    logic                 fifo_full_s, fifo_empty_s, start_ok_s, baud_end_s;
    logic [1:0]           sel_s;
    logic [CW-1:0]        fifo_count_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic [3:0]           cnt_sat_s;
    logic [7:0]           status_s;
    logic [BCW-1:0]       stop_last_s;
    logic                 unused_s;

    logic [3:0]           ctrl_q, ctrl_d, fctrl_q, fctrl_d;
    logic                 ovf_q, ovf_d, par_q, par_d, tx_q, tx_d, done_q, done_d;
    logic [2:0]           state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [BCW-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    assign access_s    = apb.PSEL && apb.PENABLE;
    assign sel_s       = apb.PADDR[3:2];
    assign wr_data_s   = access_s && apb.PWRITE && (sel_s == REG_DATA);
    assign push_s      = wr_data_s && !fifo_full_s;
    assign start_ok_s  = !fifo_empty_s && ctrl_q[CTRL_TXEN];
    assign baud_end_s  = (baud_q == BAUD_MAX);
    assign stop_last_s = {{(BCW-1){1'b0}}, fctrl_q[CTRL_STOP2]};
    assign cnt_sat_s   = (32'(fifo_count_s) > 32'd15) ? 4'hF : 4'(fifo_count_s);
    assign status_s    = {ovf_q, (state_q != S_IDLE), fifo_full_s, fifo_empty_s, cnt_sat_s};
    assign unused_s    = ^{apb.PADDR[7:4], apb.PADDR[1:0], apb.PWDATA};
    assign apb.PREADY  = 1'b1;
    assign o_tx        = tx_q;
    assign o_tx_done   = done_q;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (apb.PWDATA[DATA_BITS-1:0]),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // APB read mux, error response and register next-state.
    always_comb begin
        apb.PRDATA  = 8'h00;
        apb.PSLVERR = access_s && ((sel_s == 2'd3) || (wr_data_s && fifo_full_s));
        ctrl_d      = ctrl_q;
        ovf_d       = ovf_q;
        if (access_s && !apb.PWRITE) begin
            case (sel_s)
                REG_CTRL:   apb.PRDATA = {4'h0, ctrl_q};
                REG_STATUS: apb.PRDATA = status_s;
                default:    apb.PRDATA = 8'h00;
            endcase
        end else begin
            apb.PRDATA = 8'h00;
        end
        if (access_s && apb.PWRITE && (sel_s == REG_CTRL)) begin
            ctrl_d = apb.PWDATA[3:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_data_s && fifo_full_s) begin
            ovf_d = 1'b1;
        end else if (access_s && apb.PWRITE && (sel_s == REG_STATUS) && apb.PWDATA[STAT_OVF]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // TX frame sequencing; outputs are derived from next-state so they register cleanly.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fctrl_d  = fctrl_q;
        pop_s    = 1'b0;
        load_s   = start_ok_s && ((state_q == S_IDLE) ||
                   ((state_q == S_STOP) && baud_end_s && (bitcnt_q == stop_last_s)));
        case (state_q)
            S_START: begin
                baud_d = baud_end_s ? {BW{1'b0}} : baud_q + BW'(1);
                if (baud_end_s) begin
                    state_d  = S_DATA;
                    bitcnt_d = {BCW{1'b0}};
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                baud_d = baud_end_s ? {BW{1'b0}} : baud_q + BW'(1);
                if (baud_end_s) begin
                    shift_d = shift_q >> 1;
                    if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = {BCW{1'b0}};
                        state_d  = fctrl_q[CTRL_PAR_EN] ? S_PARITY : S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                baud_d = baud_end_s ? {BW{1'b0}} : baud_q + BW'(1);
                if (baud_end_s) begin
                    state_d  = S_STOP;
                    bitcnt_d = {BCW{1'b0}};
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                baud_d = baud_end_s ? {BW{1'b0}} : baud_q + BW'(1);
                if (baud_end_s && (bitcnt_q == stop_last_s)) begin
                    state_d  = S_IDLE;
                    bitcnt_d = {BCW{1'b0}};
                end else if (baud_end_s) begin
                    bitcnt_d = bitcnt_q + BCW'(1);
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Frame launch from IDLE or straight out of the last stop bit.
        if (load_s) begin
            state_d  = S_START;
            pop_s    = 1'b1;
            shift_d  = fifo_dout_s;
            par_d    = frame_parity(8'(fifo_dout_s), ctrl_q[CTRL_PAR_ODD]);
            fctrl_d  = ctrl_q;
            baud_d   = {BW{1'b0}};
            bitcnt_d = {BCW{1'b0}};
        end else begin
            pop_s = 1'b0;
        end
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (baud_d == BAUD_MAX) &&
                 (bitcnt_d == {{(BCW-1){1'b0}}, fctrl_d[CTRL_STOP2]});
    end

    // Register and FSM state update.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q   <= CTRL_RESET;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= {BW{1'b0}};
            bitcnt_q <= {BCW{1'b0}};
            shift_q  <= {DATA_BITS{1'b0}};
            par_q    <= 1'b0;
            fctrl_q  <= CTRL_RESET;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            fctrl_q  <= fctrl_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_apb_uart_tx_fifo.sv
// Directed bench for apb_uart_tx_fifo: an 8-bit and a 5-bit instance on private APB buses.
module tb_apb_uart_tx_fifo;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       preset, psel, penable, pwrite, sel5;
    logic [7:0] paddr, pwdata;
    logic       tx8, done8, tx5, done5;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    apb_uart_tx_fifo_if apb8();
    apb_uart_tx_fifo_if apb5();

    assign apb8.PSEL    = psel & ~sel5;
    assign apb5.PSEL    = psel & sel5;
    assign apb8.PENABLE = penable;
    assign apb5.PENABLE = penable;
    assign apb8.PWRITE  = pwrite;
    assign apb5.PWRITE  = pwrite;
    assign apb8.PADDR   = paddr;
    assign apb5.PADDR   = paddr;
    assign apb8.PWDATA  = pwdata;
    assign apb5.PWDATA  = pwdata;

    apb_uart_tx_fifo #(.CPB(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) u_dut8 (
        .PCLK(clk), .PRESET(preset), .apb(apb8), .o_tx(tx8), .o_tx_done(done8));
    apb_uart_tx_fifo #(.CPB(CPB), .DATA_BITS(5), .FIFO_DEPTH(4)) u_dut5 (
        .PCLK(clk), .PRESET(preset), .apb(apb5), .o_tx(tx5), .o_tx_done(done5));

    function automatic logic cur_tx();
        return sel5 ? tx5 : tx8;
    endfunction

    function automatic logic cur_done();
        return sel5 ? done5 : done8;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One APB transfer; returns one time unit after the commit edge.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rdata = sel5 ? apb5.PRDATA : apb8.PRDATA;
        err   = sel5 ? apb5.PSLVERR : apb8.PSLVERR;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] rd;
        logic       err;
        apb_xfer(1'b1, addr, data, rd, err);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        logic       err;
        apb_xfer(1'b0, addr, 8'h00, rd, err);
        check_eq(tag, rd, exp);
    endtask

    // Call during the first cycle of a frame; returns in the first cycle after it.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits);
        int len, dcnt, dat;
        len = nbits * CPB; dcnt = 0; dat = 0;
        check_eq({tag, "_start"}, cur_tx(), 1'b0);
        for (int c = 1; c <= len; c++) begin
            if (((c - 1) % CPB) == 1) begin
                check_eq($sformatf("%s_bit%0d", tag, (c - 1) / CPB), cur_tx(), bits[(c - 1) / CPB]);
            end
            if (cur_done()) begin
                dcnt++;
                dat = c;
            end
            @(posedge clk); #1;
        end
        check_eq({tag, "_done_cnt"}, dcnt, 1);
        check_eq({tag, "_done_at"}, dat, len);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            if (cur_done()) break;
            @(posedge clk); #1;
        end
        check_eq({tag, "_done_seen"}, 32'(k < 200), 32'd1);
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; sel5 = 1'b0;
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;

        // Reset state and register map
        check_eq("rst_tx", tx8, 1'b1);
        check_eq("rst_done", done8, 1'b0);
        check_eq("rst_prdata", apb8.PRDATA, 8'h00);
        check_eq("rst_pslverr", apb8.PSLVERR, 1'b0);
        check_eq("pready", apb8.PREADY, 1'b1);
        rd_check("rst_status", 8'h08, 8'h10);
        rd_check("rst_ctrl", 8'h04, 8'h01);
        rd_check("data_read", 8'h00, 8'h00);
        apb_xfer(1'b0, 8'h0C, 8'h00, rd, err);
        check_eq("unmapped_rd_err", err, 1'b1);
        check_eq("unmapped_rd_data", rd, 8'h00);
        apb_xfer(1'b1, 8'h0C, 8'h00, rd, err);
        check_eq("unmapped_wr_err", err, 1'b1);
        rd_check("ctrl_after_unmapped", 8'h04, 8'h01);

        // 1: 8N1 frame of 0xCC
        wr_reg(8'h00, 8'hCC);
        check_eq("t1_tx_pre", tx8, 1'b1);
        @(posedge clk); #1;
        check_frame("t1", 16'h0398, 10);
        rd_check("t1_status", 8'h08, 8'h10);

        // 2: odd parity, two stop bits, 0xA5 -> parity 1
        wr_reg(8'h04, 8'h0F);
        rd_check("t2_ctrl", 8'h04, 8'h0F);
        wr_reg(8'h00, 8'hA5);
        @(posedge clk); #1;
        check_frame("t2", 16'h0F4A, 12);
        wr_reg(8'h04, 8'h01);

        // 3: fill, overflow, OVF clear, back-to-back frames
        for (int i = 1; i <= 6; i++) begin
            apb_xfer(1'b1, 8'h00, 8'(8'h11 * i), rd, err);
            check_eq($sformatf("t3_push%0d_err", i), err, (i == 6) ? 1'b1 : 1'b0);
        end
        rd_check("t3_status_ovf", 8'h08, 8'hE4);
        wr_reg(8'h08, 8'h80);
        rd_check("t3_status_clr", 8'h08, 8'h64);
        wait_done("t3_f1");
        @(posedge clk); #1;
        check_frame("t3_f2", 16'h0244, 10);
        check_frame("t3_f3", 16'h0266, 10);
        check_frame("t3_f4", 16'h0288, 10);
        check_frame("t3_f5", 16'h02AA, 10);
        check_eq("t3_idle_tx", tx8, 1'b1);
        rd_check("t3_status_end", 8'h08, 8'h10);

        // 6: TXEN cleared mid-frame with two words queued
        wr_reg(8'h00, 8'h01);
        wr_reg(8'h00, 8'h02);
        wr_reg(8'h00, 8'h03);
        wr_reg(8'h04, 8'h00);
        rd_check("t6_ctrl", 8'h04, 8'h00);
        wait_done("t6_f1");
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge clk);
            #1 check_eq($sformatf("t6_hold%0d", i), tx8, 1'b1);
        end
        rd_check("t6_status_hold", 8'h08, 8'h02);
        wr_reg(8'h04, 8'h01);
        @(posedge clk); #1;
        check_frame("t6_f2", 16'h0204, 10);
        check_frame("t6_f3", 16'h0206, 10);
        rd_check("t6_status_end", 8'h08, 8'h10);

        // 4: 5-bit instance sends only the low five bits
        sel5 = 1'b1;
        wr_reg(8'h00, 8'hFF);
        check_eq("t4_tx_pre", tx5, 1'b1);
        @(posedge clk); #1;
        check_frame("t4", 16'h007E, 7);
        rd_check("t4_status", 8'h08, 8'h10);
        sel5 = 1'b0;

        // 5: reset in the middle of the data bits
        wr_reg(8'h04, 8'h0F);
        wr_reg(8'h00, 8'h00);
        wr_reg(8'h00, 8'h00);
        repeat (8) @(posedge clk);
        #1 check_eq("t5_mid_data", tx8, 1'b0);
        @(negedge clk); preset = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_tx_after_rst", tx8, 1'b1);
        check_eq("t5_done_after_rst", done8, 1'b0);
        preset = 1'b0;
        rd_check("t5_status", 8'h08, 8'h10);
        rd_check("t5_ctrl", 8'h04, 8'h01);
        repeat (6) @(posedge clk);
        #1 check_eq("t5_tx_stays_idle", tx8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
